// File: rtl/pc_fifo_reader_pkg.sv
// Shared types and constants for the PC/instruction-field FIFO read endpoint.
// Word width, FSM state encoding and default depth live here.
package pc_fifo_reader_pkg;

  localparam int WORD_W    = 11;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_fifo_mem.sv
// DEPTH x WORD_W register array.
// Synchronous write, combinational read, no reset on contents.
module pc_fifo_mem
  import pc_fifo_reader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_fifo_reader.sv
// Read-side endpoint of the 11-bit PC FIFO path: storage, occupancy,
// request/present/acknowledge FSM and sticky error flags.
module pc_fifo_reader
  import pc_fifo_reader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              rd_req,
  input  logic              rd_ack,
  output logic [WORD_W-1:0] P,
  output logic              p_valid,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t            state;
  state_t            state_n;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [WORD_W-1:0] rdata;
  logic              pop;
  logic              udf_set;
  logic              accept;
  logic              ovf_set;

  pc_fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (accept),
    .waddr(wptr),
    .wdata(push_data),
    .raddr(rptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // empty reflects occupancy at cycle start, so a same-cycle push
  // can never be popped: the word is seen one cycle later.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    udf_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_req) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = PRESENT;
          end else begin
            udf_set = 1'b1;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (rd_ack) begin
          if (rd_req && !empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    p_valid = (state == PRESENT);
    empty   = (count == '0);
    full    = (count == CNT_MAX);
    accept  = push && (!full || pop);
    ovf_set = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      P       <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (pop) begin
        P    <= rdata;
        rptr <= rptr + PTR_ONE;
      end
      if (accept) begin
        wptr <= wptr + PTR_ONE;
      end
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf_err <= 1'b1;
      end
      if (udf_set) begin
        udf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fifo_reader.sv
// Directed bench for pc_fifo_reader: vector table plus
// hand-written multi-cycle sequences.
module tb_pc_fifo_reader;

  logic        clk;
  logic        clear;
  logic        push;
  logic [10:0] push_data;
  logic        rd_req;
  logic        rd_ack;
  logic [10:0] P;
  logic        p_valid;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        ovf_err;
  logic        udf_err;

  int n_run;
  int n_fail;

  pc_fifo_reader #(.DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .clear    (clear),
    .push     (push),
    .push_data(push_data),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .P        (P),
    .p_valid  (p_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        psh;
    logic [10:0] d;
    logic        req;
    logic        ack;
    logic [10:0] p;
    logic        pv;
    logic [3:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vec [17];

  function automatic vec_t mk(
    logic c, logic ps, logic [10:0] d, logic rq, logic ak,
    logic [10:0] p, logic pv, logic [3:0] cn,
    logic em, logic fu, logic ov, logic ud);
    vec_t v;
    v.clr = c;  v.psh = ps; v.d = d; v.req = rq; v.ack = ak;
    v.p = p;    v.pv = pv;  v.cnt = cn; v.emp = em; v.ful = fu;
    v.ovf = ov; v.udf = ud;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(logic c, logic ps, logic [10:0] d,
                      logic rq, logic ak);
    clear     = c;
    push      = ps;
    push_data = d;
    rd_req    = rq;
    rd_ack    = ak;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    clear = 1'b1; push = 1'b0; push_data = '0;
    rd_req = 1'b0; rd_ack = 1'b0;

    //            clr ps data    rq ak  P      pv cnt em fu ov ud
    vec[0]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1, 0, 0, 0);
    vec[1]  = mk(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1, 0, 0, 0);
    vec[2]  = mk(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1, 0, 0, 0);
    vec[3]  = mk(0, 1, 11'h123, 0, 0, 11'h000, 0, 1, 0, 0, 0, 0);
    vec[4]  = mk(0, 1, 11'h7FF, 0, 0, 11'h000, 0, 2, 0, 0, 0, 0);
    vec[5]  = mk(0, 1, 11'h001, 0, 0, 11'h000, 0, 3, 0, 0, 0, 0);
    vec[6]  = mk(0, 0, 11'h000, 1, 0, 11'h123, 1, 2, 0, 0, 0, 0);
    vec[7]  = mk(0, 0, 11'h000, 0, 1, 11'h123, 0, 2, 0, 0, 0, 0);
    vec[8]  = mk(0, 0, 11'h000, 1, 0, 11'h7FF, 1, 1, 0, 0, 0, 0);
    vec[9]  = mk(0, 0, 11'h000, 0, 1, 11'h7FF, 0, 1, 0, 0, 0, 0);
    vec[10] = mk(0, 0, 11'h000, 1, 0, 11'h001, 1, 0, 1, 0, 0, 0);
    vec[11] = mk(0, 0, 11'h000, 0, 1, 11'h001, 0, 0, 1, 0, 0, 0);
    vec[12] = mk(0, 0, 11'h000, 1, 0, 11'h001, 0, 0, 1, 0, 0, 1);
    vec[13] = mk(0, 1, 11'h555, 0, 0, 11'h001, 0, 1, 0, 0, 0, 1);
    vec[14] = mk(0, 0, 11'h000, 0, 0, 11'h555, 1, 0, 1, 0, 0, 1);
    vec[15] = mk(0, 0, 11'h000, 0, 1, 11'h555, 0, 0, 1, 0, 0, 1);
    vec[16] = mk(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      step(vec[i].clr, vec[i].psh, vec[i].d, vec[i].req, vec[i].ack);
      chk($sformatf("v%0d P", i), int'(P), int'(vec[i].p));
      chk($sformatf("v%0d p_valid", i), int'(p_valid), int'(vec[i].pv));
      chk($sformatf("v%0d count", i), int'(count), int'(vec[i].cnt));
      chk($sformatf("v%0d empty", i), int'(empty), int'(vec[i].emp));
      chk($sformatf("v%0d full", i), int'(full), int'(vec[i].ful));
      chk($sformatf("v%0d ovf", i), int'(ovf_err), int'(vec[i].ovf));
      chk($sformatf("v%0d udf", i), int'(udf_err), int'(vec[i].udf));
    end

    // Full and overflow
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 11'(16 + i), 0, 0);
      if (i == 7) chk("ovf full@8", int'(full), 1);
      if (i == 7) chk("ovf no err@8", int'(ovf_err), 0);
    end
    chk("ovf err", int'(ovf_err), 1);
    chk("ovf count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("ovf rd%0d P", i), int'(P), 16 + i);
      chk($sformatf("ovf rd%0d pv", i), int'(p_valid), 1);
      step(0, 0, 0, 0, 1);
    end
    chk("ovf drained empty", int'(empty), 1);

    // Full with same-cycle back-to-back pop
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 11'(256 + i), 0, 0);
    step(0, 0, 0, 1, 0);
    chk("fp first P", int'(P), 256);
    step(0, 1, 11'h108, 0, 0);
    chk("fp refill full", int'(full), 1);
    step(0, 1, 11'h2AA, 1, 1);
    chk("fp b2b P", int'(P), 257);
    chk("fp b2b count", int'(count), 8);
    chk("fp b2b ovf", int'(ovf_err), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1);
      chk($sformatf("fp rd%0d P", i), int'(P),
          (i == 7) ? 'h2AA : 258 + i);
      chk($sformatf("fp rd%0d pv", i), int'(p_valid), 1);
    end
    chk("fp drained count", int'(count), 0);
    step(0, 0, 0, 0, 1);
    chk("fp final pv", int'(p_valid), 0);

    // Wrap-around: 20 push/pop pairs
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 11'(('h3C5 * (i + 1)) & 'h7FF), 0, 0);
      chk($sformatf("wr%0d cnt1", i), int'(count), 1);
      step(0, 0, 0, 1, 0);
      chk($sformatf("wr%0d P", i), int'(P), ('h3C5 * (i + 1)) & 'h7FF);
      chk($sformatf("wr%0d cnt0", i), int'(count), 0);
      step(0, 0, 0, 0, 1);
    end

    // Clear in PRESENT with 3 words buffered and udf set
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("cl udf set", int'(udf_err), 1);
    step(0, 1, 11'h00A, 0, 0);
    chk("cl wait pv", int'(p_valid), 0);
    step(0, 1, 11'h00B, 0, 0);
    chk("cl wait pop P", int'(P), 'h00A);
    step(0, 1, 11'h00C, 0, 0);
    step(0, 1, 11'h00D, 0, 0);
    chk("cl pre count", int'(count), 3);
    chk("cl pre pv", int'(p_valid), 1);
    step(1, 0, 0, 0, 0);
    chk("cl pv", int'(p_valid), 0);
    chk("cl count", int'(count), 0);
    chk("cl empty", int'(empty), 1);
    chk("cl udf", int'(udf_err), 0);
    chk("cl ovf", int'(ovf_err), 0);
    chk("cl P", int'(P), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
